// File: rtl/fifo_pkg.sv
// Shared constants and the byte-ordering helper for the word-in / byte-out FIFO.
// Optional feature macro: FIFO_BIG_ENDIAN_EN (defined -> high byte of each word is emitted first).
package fifo_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int DIN_W      = 16;
  localparam int DOUT_W     = 8;
  localparam int PTR_W      = 4;
  localparam int CNT_W      = 5;

  // Pick the byte of a stored word that goes out for the given half:
  // second_half = 0 selects the first byte of the word, 1 the second byte.
  function automatic logic [DOUT_W-1:0] select_byte(input logic [DIN_W-1:0] word,
                                                    input logic             second_half);
`ifdef FIFO_BIG_ENDIAN_EN
    if (second_half) begin
      return word[7:0];
    end else begin
      return word[15:8];
    end
`else
    if (second_half) begin
      return word[15:8];
    end else begin
      return word[7:0];
    end
`endif
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// 16 x 16 storage array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers in the top level.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [DIN_W-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [DIN_W-1:0] rdata_o
);

  logic [DIN_W-1:0] mem_q [FIFO_DEPTH];

  // Capture the write word into the addressed slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// Word-in / byte-out FIFO: 16 words of 16 bits are written, read back one byte per pop.
// Each word is emitted as two bytes; the word slot is freed when its second byte pops.
// Optional feature macro: FIFO_BIG_ENDIAN_EN (see fifo_pkg::select_byte for byte order).
// Note: rst_n is active-HIGH despite its name.
module fifo
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              input_valid,
  output logic              input_enable,
  input  logic [DIN_W-1:0]  data_in,
  output logic              output_valid,
  input  logic              output_enable,
  output logic [DOUT_W-1:0] data_out,
  input  logic [DIN_W-1:0]  d
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              byte_sel_q, byte_sel_d;
  logic [DOUT_W-1:0] data_out_q, data_out_d;

  logic              wr_en;
  logic              pop;
  logic              word_done;
  logic [DIN_W-1:0]  rd_word;
  logic [DOUT_W-1:0] rd_byte;
  logic              unused_d;

  // The reserved input has no function; fold it so it is visibly consumed.
  assign unused_d = ^d;

  assign input_enable = (count_q < CNT_W'(FIFO_DEPTH));
  assign output_valid = (count_q != {CNT_W{1'b0}});
  assign wr_en        = input_valid && input_enable;
  assign pop          = output_enable && output_valid;
  // The second byte of a word completes it and releases its slot.
  assign word_done    = pop && byte_sel_q;
  assign rd_byte      = select_byte(rd_word, byte_sel_q);
  assign data_out     = data_out_q;

  fifo_mem u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  // Next-state for pointers, occupancy, byte selector and the output byte register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    byte_sel_d = byte_sel_q;
    data_out_d = data_out_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      data_out_d = rd_byte;
      byte_sel_d = ~byte_sel_q;
    end else begin
      data_out_d = data_out_q;
      byte_sel_d = byte_sel_q;
    end

    if (word_done) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A write together with a word-completing pop leaves occupancy unchanged.
    case ({wr_en, word_done})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards stored words and any half-read word.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      byte_sel_q <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byte_sel_q <= byte_sel_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed table of per-cycle vectors plus hand-written
// sequences for fill/drain, empty reads, full-with-simultaneous-pop, interleaving and reset.
module tb_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        input_valid;
  logic        input_enable;
  logic [15:0] data_in;
  logic        output_valid;
  logic        output_enable;
  logic [7:0]  data_out;
  logic [15:0] d;

  int n_checks = 0;
  int n_fail   = 0;

  fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_valid   (input_valid),
    .input_enable  (input_enable),
    .data_in       (data_in),
    .output_valid  (output_valid),
    .output_enable (output_enable),
    .data_out      (data_out),
    .d             (d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        oe;
    logic        ie;
    logic        ov;
    logic [7:0]  dout;
  } vec_t;

  vec_t tbl [11];

  // Expected byte n (0 = first emitted, 1 = second) of a word.
  function automatic logic [7:0] byte_of(input logic [15:0] w, input int n);
`ifdef FIFO_BIG_ENDIAN_EN
    return (n == 0) ? w[15:8] : w[7:0];
`else
    return (n == 0) ? w[7:0] : w[15:8];
`endif
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic iv, input logic [15:0] din, input logic oe);
    @(negedge clk);
    input_valid   = iv;
    data_in       = din;
    output_enable = oe;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    input_valid   = 1'b0;
    output_enable = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  function automatic logic [15:0] fill_word(input int i);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(i + 100);
    lo = 8'(i);
    return {hi, lo};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  last;
    logic [7:0]  exp_q [$];
    logic [7:0]  eb;
    int          wr_idx;
    int          gap;
    int          got;
    logic        iv;
    logic        pop_pred;

    rst_n         = 1'b1;
    input_valid   = 1'b0;
    output_enable = 1'b0;
    data_in       = 16'h0000;
    d             = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_ov", output_valid, 1'b0);
    chk1("reset_ie", input_enable, 1'b1);
    chk8("reset_dout", data_out, 8'h00);
    rst_n = 1'b0;

    // Fill with 16 words; input_enable falls after the 16th.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, fill_word(i), 1'b0);
      chk1("fill_ie", input_enable, (i < 15));
      chk1("fill_ov", output_valid, 1'b1);
    end
    step(1'b1, 16'hDEAD, 1'b0);
    chk1("full_17th_ie", input_enable, 1'b0);
    chk8("full_17th_dout", data_out, 8'h00);

    // Drain all 32 bytes in order; the 17th word must not appear.
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 16'h0000, 1'b1);
      chk8("drain_dout", data_out, byte_of(fill_word(k / 2), k % 2));
      chk1("drain_ov", output_valid, (k < 31));
      chk1("drain_ie", input_enable, (k >= 1));
    end
    last = data_out;

    // Reading while empty changes nothing.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0000, 1'b1);
      chk1("empty_ov", output_valid, 1'b0);
      chk8("empty_dout", data_out, last);
    end

    // Table-driven single-cycle vectors from a fresh reset.
    tbl[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, byte_of(16'hA5A5, 0)};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, byte_of(16'hA5A5, 1)};
    tbl[3]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, byte_of(16'hA5A5, 1)};
    tbl[4]  = '{1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, byte_of(16'h1234, 0)};
    tbl[5]  = '{1'b1, 16'h9ABC, 1'b1, 1'b1, 1'b1, byte_of(16'h1234, 1)};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, byte_of(16'h5678, 0)};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, byte_of(16'h5678, 1)};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, byte_of(16'h9ABC, 0)};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, byte_of(16'h9ABC, 1)};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, byte_of(16'h9ABC, 1)};

    do_reset();
    #1;
    chk1("rst2_ov", output_valid, 1'b0);
    chk8("rst2_dout", data_out, 8'h00);
    for (int v = 0; v < 11; v++) begin
      step(tbl[v].iv, tbl[v].din, tbl[v].oe);
      chk1("tbl_ie", input_enable, tbl[v].ie);
      chk1("tbl_ov", output_valid, tbl[v].ov);
      chk8("tbl_dout", data_out, tbl[v].dout);
    end

    // Full FIFO: write attempted in the same cycle as a word-completing pop is refused.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, fill_word(i + 20), 1'b0);
    end
    chk1("full2_ie", input_enable, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    chk8("full2_lo", data_out, byte_of(fill_word(20), 0));
    step(1'b1, 16'hFFFF, 1'b1);
    chk8("full2_hi", data_out, byte_of(fill_word(20), 1));
    chk1("full2_ie_after", input_enable, 1'b1);
    for (int k = 2; k < 32; k++) begin
      step(1'b0, 16'h0000, 1'b1);
      chk8("full2_drain", data_out, byte_of(fill_word(k / 2 + 20), k % 2));
    end
    chk1("full2_empty_ov", output_valid, 1'b0);

    // Interleaved writes with gaps while reading continuously.
    do_reset();
    wr_idx = 0;
    gap    = 0;
    got    = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (wr_idx == 8 && exp_q.size() == 0) break;
      iv       = (wr_idx < 8) && (gap == 0);
      w        = {8'(wr_idx + 200), 8'(wr_idx + 50)};
      pop_pred = (exp_q.size() > 0);
      step(iv, w, 1'b1);
      if (pop_pred) begin
        eb = exp_q.pop_front();
        chk8("inter_dout", data_out, eb);
        got++;
      end
      if (iv) begin
        exp_q.push_back(byte_of(w, 0));
        exp_q.push_back(byte_of(w, 1));
        wr_idx++;
        gap = (wr_idx % 3) + 1;
      end else if (gap > 0) begin
        gap--;
      end
      chk1("inter_ov", output_valid, (exp_q.size() > 0));
    end
    chki("inter_bytes", got, 16);

    // Reset in the middle of a word.
    do_reset();
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    chk8("midrst_lo", data_out, byte_of(16'hBEEF, 0));
    @(negedge clk);
    output_enable = 1'b0;
    rst_n         = 1'b1;
    #1;
    chk1("midrst_ov", output_valid, 1'b0);
    chk1("midrst_ie", input_enable, 1'b1);
    chk8("midrst_dout", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b1, 16'h4321, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    chk8("midrst_next0", data_out, byte_of(16'h4321, 0));
    step(1'b0, 16'h0000, 1'b1);
    chk8("midrst_next1", data_out, byte_of(16'h4321, 1));
    chk1("midrst_next_ov", output_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
